// File: rtl/reduced_round_axi_pkg.sv
// Shared definitions for the reduced-round accelerator AXI4-Lite register slave.
// Holds register index constants, the write/read channel state encodings and
// the AXI response code.
package reduced_round_axi_pkg;

    localparam int unsigned NUM_REGS = 4;

    localparam int unsigned REG_CTRL   = 0;
    localparam int unsigned REG_KEY    = 1;
    localparam int unsigned REG_DATA   = 2;
    localparam int unsigned REG_RESULT = 3;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_ADDR,
        W_HAVE_DATA,
        W_RESP
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_e;

endpackage

// File: rtl/byte_strobe_merge.sv
// Byte-lane merge for a register write.
// Ports:
//   old_word_i - current register value
//   wdata_i    - incoming write data
//   wstrb_i    - byte enables, bit k selects wdata_i[8k+7:8k]
//   new_word_o - merged word; lanes with a clear strobe keep old_word_i
module byte_strobe_merge #(
    parameter int unsigned DataWidth = 32
) (
    input  logic [DataWidth-1:0]   old_word_i,
    input  logic [DataWidth-1:0]   wdata_i,
    input  logic [DataWidth/8-1:0] wstrb_i,
    output logic [DataWidth-1:0]   new_word_o
);

    always_comb begin
        new_word_o = old_word_i;
        for (int unsigned k = 0; k < DataWidth / 8; k++) begin
            if (wstrb_i[k]) begin
                new_word_o[8*k +: 8] = wdata_i[8*k +: 8];
            end
        end
    end

endmodule

// File: rtl/reduced_round_axi_slave_regs.sv
// AXI4-Lite slave holding four 32-bit read/write registers for the
// reduced-round four-core datapath.
// Ports:
//   s00_axi_aclk / s00_axi_areset - clock and synchronous active-high reset
//   s00_axi_aw*, s00_axi_w*, s00_axi_b* - write address, data and response channels
//   s00_axi_ar*, s00_axi_r*             - read address and data channels
//   reg_q        - current register contents, reg_q[0..3]
//   reg_wr_pulse - one-hot, high for one cycle after register n is written
module reduced_round_axi_slave_regs
    import reduced_round_axi_pkg::*;
#(
    parameter integer C_S_AXI_DATA_WIDTH = 32,
    parameter integer C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                                         s00_axi_aclk,
    input  logic                                         s00_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]                s00_axi_awaddr,
    input  logic [2:0]                                   s00_axi_awprot,
    input  logic                                         s00_axi_awvalid,
    output logic                                         s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]                s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]              s00_axi_wstrb,
    input  logic                                         s00_axi_wvalid,
    output logic                                         s00_axi_wready,
    output logic [1:0]                                   s00_axi_bresp,
    output logic                                         s00_axi_bvalid,
    input  logic                                         s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]                s00_axi_araddr,
    input  logic [2:0]                                   s00_axi_arprot,
    input  logic                                         s00_axi_arvalid,
    output logic                                         s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]                s00_axi_rdata,
    output logic [1:0]                                   s00_axi_rresp,
    output logic                                         s00_axi_rvalid,
    input  logic                                         s00_axi_rready,
    output logic [NUM_REGS-1:0][C_S_AXI_DATA_WIDTH-1:0]  reg_q,
    output logic [NUM_REGS-1:0]                          reg_wr_pulse
);

    localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
    localparam int unsigned SW = C_S_AXI_DATA_WIDTH / 8;

    wr_state_e                   wr_state_q, wr_state_d;
    rd_state_e                   rd_state_q, rd_state_d;
    logic [1:0]                  wr_idx_q, wr_idx_d;
    logic [DW-1:0]               wdata_q, wdata_d;
    logic [SW-1:0]               wstrb_q, wstrb_d;
    logic [NUM_REGS-1:0][DW-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]         pulse_q, pulse_d;
    logic [DW-1:0]               rdata_q, rdata_d;

    logic          aw_hs, w_hs, ar_hs;
    logic          wr_complete;
    logic [1:0]    cur_idx;
    logic [DW-1:0] cur_data;
    logic [SW-1:0] cur_strb;
    logic [DW-1:0] merged_word;

    // Protection bits and the byte-offset address bits carry no meaning here.
    logic unused_inputs;
    assign unused_inputs = ^{s00_axi_awaddr, s00_axi_araddr, s00_axi_awprot, s00_axi_arprot};

    // Handshake outputs are held low for as long as reset is asserted.
    assign s00_axi_awready = !s00_axi_areset &&
                             (wr_state_q == W_IDLE || wr_state_q == W_HAVE_DATA);
    assign s00_axi_wready  = !s00_axi_areset &&
                             (wr_state_q == W_IDLE || wr_state_q == W_HAVE_ADDR);
    assign s00_axi_bvalid  = !s00_axi_areset && (wr_state_q == W_RESP);
    assign s00_axi_arready = !s00_axi_areset && (rd_state_q == R_IDLE);
    assign s00_axi_rvalid  = !s00_axi_areset && (rd_state_q == R_DATA);

    assign s00_axi_bresp = AXI_RESP_OKAY;
    assign s00_axi_rresp = AXI_RESP_OKAY;
    assign s00_axi_rdata = rdata_q;
    assign reg_q         = regs_q;
    assign reg_wr_pulse  = pulse_q;

    assign aw_hs = s00_axi_awvalid && s00_axi_awready;
    assign w_hs  = s00_axi_wvalid && s00_axi_wready;
    assign ar_hs = s00_axi_arvalid && s00_axi_arready;

    // The completing beat may arrive in the same cycle as the write, so use
    // the live bus value in preference to the latched copy.
    assign cur_idx  = aw_hs ? s00_axi_awaddr[3:2] : wr_idx_q;
    assign cur_data = w_hs ? s00_axi_wdata : wdata_q;
    assign cur_strb = w_hs ? s00_axi_wstrb : wstrb_q;

    byte_strobe_merge #(
        .DataWidth (DW)
    ) u_merge (
        .old_word_i (regs_q[cur_idx]),
        .wdata_i    (cur_data),
        .wstrb_i    (cur_strb),
        .new_word_o (merged_word)
    );

    // Write channel
    always_comb begin
        wr_state_d  = wr_state_q;
        wr_idx_d    = wr_idx_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        regs_d      = regs_q;
        pulse_d     = '0;
        wr_complete = 1'b0;

        if (aw_hs) begin
            wr_idx_d = s00_axi_awaddr[3:2];
        end
        if (w_hs) begin
            wdata_d = s00_axi_wdata;
            wstrb_d = s00_axi_wstrb;
        end

        unique case (wr_state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    wr_complete = 1'b1;
                end else if (aw_hs) begin
                    wr_state_d = W_HAVE_ADDR;
                end else if (w_hs) begin
                    wr_state_d = W_HAVE_DATA;
                end
            end
            W_HAVE_ADDR: wr_complete = w_hs;
            W_HAVE_DATA: wr_complete = aw_hs;
            W_RESP: begin
                if (s00_axi_bready) begin
                    wr_state_d = W_IDLE;
                end
            end
        endcase

        if (wr_complete) begin
            wr_state_d       = W_RESP;
            regs_d[cur_idx]  = merged_word;
            pulse_d[cur_idx] = 1'b1;
        end
    end

    // Read channel; samples regs_q so a same-edge write is not yet visible.
    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        unique case (rd_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    rdata_d    = regs_q[s00_axi_araddr[3:2]];
                    rd_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (s00_axi_rready) begin
                    rd_state_d = R_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            wr_state_q <= W_IDLE;
            rd_state_q <= R_IDLE;
            wr_idx_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            regs_q     <= '0;
            pulse_q    <= '0;
            rdata_q    <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            wr_idx_q   <= wr_idx_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            regs_q     <= regs_d;
            pulse_q    <= pulse_d;
            rdata_q    <= rdata_d;
        end
    end

endmodule

// File: tb/tb_reduced_round_axi_slave_regs.sv
// Directed bench for reduced_round_axi_slave_regs with a transaction-level
// reference model checked against the DUT every cycle.
module tb_reduced_round_axi_slave_regs;
    import reduced_round_axi_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             areset;
    logic [3:0]       awaddr;
    logic [2:0]       awprot;
    logic             awvalid, awready;
    logic [31:0]      wdata;
    logic [3:0]       wstrb;
    logic             wvalid, wready;
    logic [1:0]       bresp;
    logic             bvalid, bready;
    logic [3:0]       araddr;
    logic [2:0]       arprot;
    logic             arvalid, arready;
    logic [31:0]      rdata;
    logic [1:0]       rresp;
    logic             rvalid, rready;
    logic [3:0][31:0] reg_q;
    logic [3:0]       reg_wr_pulse;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    reduced_round_axi_slave_regs #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (4)
    ) dut (
        .s00_axi_aclk    (clk),
        .s00_axi_areset  (areset),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awprot  (awprot),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_araddr  (araddr),
        .s00_axi_arprot  (arprot),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready),
        .reg_q           (reg_q),
        .reg_wr_pulse    (reg_wr_pulse)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out waiting for handshake at %0t", name, $time);
    endtask

    // Reference model: tracks which halves of a write have been accepted,
    // whether a response is owed on B or R, and the register contents.
    logic [31:0] m_regs [4];
    logic [31:0] m_rdata  = '0;
    logic [3:0]  m_addr   = '0;
    logic [31:0] m_data   = '0;
    logic [3:0]  m_strb   = '0;
    logic [3:0]  m_pulse  = '0;
    bit          m_aw_got = 0;
    bit          m_w_got  = 0;
    bit          m_b_pend = 0;
    bit          m_r_pend = 0;

    always @(posedge clk) begin : model
        bit ahs, whs, arhs, bhs, rhs;
        int idx;
        if (areset) begin
            for (int i = 0; i < 4; i++) m_regs[i] = '0;
            m_rdata  = '0;
            m_pulse  = '0;
            m_aw_got = 0;
            m_w_got  = 0;
            m_b_pend = 0;
            m_r_pend = 0;
        end else begin
            ahs  = awvalid && !m_aw_got && !m_b_pend;
            whs  = wvalid && !m_w_got && !m_b_pend;
            arhs = arvalid && !m_r_pend;
            bhs  = bready && m_b_pend;
            rhs  = rready && m_r_pend;
            m_pulse = '0;
            if (arhs) m_rdata = m_regs[araddr / 4];
            if (ahs) m_addr = awaddr;
            if (whs) begin
                m_data = wdata;
                m_strb = wstrb;
            end
            if ((ahs || m_aw_got) && (whs || m_w_got)) begin
                idx = m_addr / 4;
                for (int k = 0; k < 4; k++) begin
                    if (m_strb[k]) m_regs[idx][8*k +: 8] = m_data[8*k +: 8];
                end
                m_pulse  = 4'(1 << idx);
                m_aw_got = 0;
                m_w_got  = 0;
                m_b_pend = 1;
            end else begin
                if (ahs) m_aw_got = 1;
                if (whs) m_w_got = 1;
                if (bhs) m_b_pend = 0;
            end
            if (rhs) m_r_pend = 0;
            if (arhs) m_r_pend = 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check_bit("awready", awready, !areset && !m_aw_got && !m_b_pend);
            check_bit("wready", wready, !areset && !m_w_got && !m_b_pend);
            check_bit("bvalid", bvalid, !areset && m_b_pend);
            check_bit("arready", arready, !areset && !m_r_pend);
            check_bit("rvalid", rvalid, !areset && m_r_pend);
            check("bresp", 32'(bresp), 32'(AXI_RESP_OKAY));
            check("rresp", 32'(rresp), 32'(AXI_RESP_OKAY));
            check("reg_wr_pulse", 32'(reg_wr_pulse), 32'(m_pulse));
            for (int i = 0; i < 4; i++) begin
                check($sformatf("reg_q%0d", i), reg_q[i], m_regs[i]);
            end
            if (m_r_pend && !areset) check("rdata", rdata, m_rdata);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_aw(input logic [3:0] addr);
        awaddr  = addr;
        awvalid = 1'b1;
    endtask

    task automatic start_w(input logic [31:0] data, input logic [3:0] strb);
        wdata  = data;
        wstrb  = strb;
        wvalid = 1'b1;
    endtask

    // Drives AW/W until both are accepted; returns at +1 after the final edge.
    task automatic finish_aw_w();
        bit a_done, w_done;
        int n = 0;
        while ((awvalid || wvalid) && n < 20) begin
            @(negedge clk);
            a_done = awvalid && awready;
            w_done = wvalid && wready;
            step();
            if (a_done) awvalid = 1'b0;
            if (w_done) wvalid = 1'b0;
            n++;
        end
        if (awvalid || wvalid) begin
            timeout_fail("aw_w_accept");
            awvalid = 1'b0;
            wvalid  = 1'b0;
        end
    endtask

    // Waits for B; reports the pulse seen with bvalid and cycles waited.
    task automatic wait_b(output logic [3:0] pulse, output int lat);
        bit done = 0;
        pulse = 'x;
        lat   = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            if (bvalid) pulse = reg_wr_pulse;
            done = bvalid && bready;
            step();
            if (!done) lat++;
        end
        if (!done) timeout_fail("b_response");
    endtask

    task automatic do_read(input logic [3:0] addr, output logic [31:0] data);
        bit a_done = 0;
        bit r_done = 0;
        int n = 0;
        araddr  = addr;
        arvalid = 1'b1;
        while (!a_done && n < 20) begin
            @(negedge clk);
            a_done = arready;
            step();
            n++;
        end
        arvalid = 1'b0;
        if (!a_done) timeout_fail("ar_accept");
        n    = 0;
        data = 'x;
        while (!r_done && n < 20) begin
            @(negedge clk);
            if (rvalid) data = rdata;
            r_done = rvalid && rready;
            step();
            n++;
        end
        if (!r_done) timeout_fail("r_response");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin
        logic [3:0]  p;
        logic [31:0] d;
        int          lat;

        areset  = 1'b1;
        awaddr  = '0;
        awprot  = '0;
        awvalid = 1'b0;
        wdata   = '0;
        wstrb   = '0;
        wvalid  = 1'b0;
        bready  = 1'b1;
        araddr  = '0;
        arprot  = '0;
        arvalid = 1'b0;
        rready  = 1'b1;

        step();
        chk_en = 1'b1;
        @(negedge clk);
        check_bit("rst_awready_low", awready, 1'b0);
        check_bit("rst_arready_low", arready, 1'b0);
        step();
        areset = 1'b0;
        @(negedge clk);
        check_bit("post_rst_awready", awready, 1'b1);
        check_bit("post_rst_wready", wready, 1'b1);
        check_bit("post_rst_arready", arready, 1'b1);
        check("post_rst_rdata", rdata, 32'h0);
        step();

        // Fill all four registers, then read back.
        for (int i = 0; i < 4; i++) begin
            start_aw(4'(i * 4));
            start_w(32'(i + 1), 4'hF);
            finish_aw_w();
            wait_b(p, lat);
            check($sformatf("fill_pulse%0d", i), 32'(p), 32'(1 << i));
        end
        for (int i = 0; i < 4; i++) begin
            do_read(4'(i * 4), d);
            check($sformatf("fill_read%0d", i), d, 32'(i + 1));
        end

        // W beat three cycles ahead of AW.
        start_w(32'hDEADBEEF, 4'hF);
        @(negedge clk);
        check_bit("early_w_wready", wready, 1'b1);
        step();
        wvalid = 1'b0;
        @(negedge clk);
        check_bit("early_w_wready_drop", wready, 1'b0);
        step();
        step();
        start_aw(4'(REG_DATA * 4));
        finish_aw_w();
        wait_b(p, lat);
        check("early_w_b_latency", 32'(lat), 32'd0);
        check("early_w_pulse", 32'(p), 32'b0100);
        check("early_w_reg2", reg_q[REG_DATA], 32'hDEADBEEF);

        // Single byte lane write onto reg0 = 1.
        start_aw(4'(REG_CTRL * 4));
        start_w(32'hAABBCCDD, 4'b0010);
        finish_aw_w();
        wait_b(p, lat);
        do_read(4'h0, d);
        check("strobe_read", d, 32'h0000CC01);

        // B back-pressure blocks a second write.
        bready = 1'b0;
        start_aw(4'hC);
        start_w(32'h11111111, 4'hF);
        finish_aw_w();
        start_aw(4'hC);
        start_w(32'h44444444, 4'hF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_bit("bp_bvalid", bvalid, 1'b1);
            check_bit("bp_awready", awready, 1'b0);
            check_bit("bp_wready", wready, 1'b0);
            step();
        end
        bready = 1'b1;
        @(negedge clk);
        check_bit("bp_aw_still_blocked", awready, 1'b0);
        step();
        @(negedge clk);
        check_bit("bp_aw_after_bready", awready, 1'b1);
        step();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        wait_b(p, lat);
        check("bp_pulse", 32'(p), 32'b1000);
        check("bp_reg3", reg_q[REG_RESULT], 32'h44444444);

        // Read and completing write to reg1 on the same edge.
        start_aw(4'(REG_KEY * 4));
        start_w(32'h55, 4'hF);
        araddr  = 4'h4;
        arvalid = 1'b1;
        @(negedge clk);
        check_bit("rw_awready", awready, 1'b1);
        check_bit("rw_arready", arready, 1'b1);
        step();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        arvalid = 1'b0;
        @(negedge clk);
        check_bit("rw_rvalid", rvalid, 1'b1);
        check("rw_old_rdata", rdata, 32'h2);
        step();
        do_read(4'h4, d);
        check("rw_new_rdata", d, 32'h55);

        // Reset with a partial write and an unread response outstanding.
        rready  = 1'b0;
        araddr  = 4'h0;
        arvalid = 1'b1;
        start_aw(4'h8);
        @(negedge clk);
        step();
        arvalid = 1'b0;
        awvalid = 1'b0;
        @(negedge clk);
        check_bit("mid_rvalid", rvalid, 1'b1);
        check_bit("mid_awready", awready, 1'b0);
        check_bit("mid_wready", wready, 1'b1);
        step();
        areset = 1'b1;
        @(negedge clk);
        check_bit("in_rst_rvalid", rvalid, 1'b0);
        check_bit("in_rst_wready", wready, 1'b0);
        step();
        areset = 1'b0;
        rready = 1'b1;
        @(negedge clk);
        check_bit("after_rst_bvalid", bvalid, 1'b0);
        check_bit("after_rst_rvalid", rvalid, 1'b0);
        check_bit("after_rst_awready", awready, 1'b1);
        check_bit("after_rst_wready", wready, 1'b1);
        check_bit("after_rst_arready", arready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("after_rst_reg%0d", i), reg_q[i], 32'h0);
        end
        step();

        // Fresh write after recovery.
        start_aw(4'h7);
        start_w(32'h77, 4'hF);
        finish_aw_w();
        wait_b(p, lat);
        check("recover_pulse", 32'(p), 32'b0010);
        do_read(4'h5, d);
        check("recover_read", d, 32'h77);

        repeat (2) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
